// File: rtl/crypto1_sched.sv
//==============================================================================
// Module   : crypto1_sched
// Brief    : Job scheduler for a farm of NCORES Crypto1 key-search cores.
//            Splits the 48-bit key space into 256 (even, odd) index jobs. It
//            dispatches them to idle cores and collects DONE/VALID/KEY. The
//            search stops on the first recovered key or when all jobs retire.
// Options  : CRYPTO1_SCHED_ABORT_EN - adds the ABORT input, which ends a
//            running search early with FOUND=0.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module crypto1_sched #(
   parameter int NCORES     = 4,
   parameter int RST_CYCLES = 2
) (
   input  logic                   CLK,
   input  logic                   RESETn,
   input  logic                   START,
   input  logic [47:0]            BITSTREAM,
`ifdef CRYPTO1_SCHED_ABORT_EN
   input  logic                   ABORT,
`endif
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   FOUND,
   output logic [47:0]            KEY,
   output logic [8:0]             JOBS_DONE,
   output logic [47:0]            CORE_BITSTREAM,
   output logic [NCORES-1:0]      CORE_RESETn,
   output logic [4*NCORES-1:0]    CORE_EIDX,
   output logic [4*NCORES-1:0]    CORE_OIDX,
   input  logic [NCORES-1:0]      CORE_DONE,
   input  logic [NCORES-1:0]      CORE_VALID,
   input  logic [48*NCORES-1:0]   CORE_KEY
);

   localparam int                  c_CNT_W     = $clog2(RST_CYCLES + 1);
   localparam int                  c_POP_W     = $clog2(NCORES + 1);
   localparam logic [c_CNT_W-1:0]  c_HOLD_LOAD = c_CNT_W'(RST_CYCLES - 1);
   localparam logic [8:0]          c_JOB_TOTAL = 9'd256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } top_state_t;

   typedef enum logic [1:0] {
      SL_IDLE = 2'd0,
      SL_HOLD = 2'd1,
      SL_RUN  = 2'd2
   } slot_state_t;

   top_state_t          r_state;
   slot_state_t         r_slot     [NCORES];
   logic [c_CNT_W-1:0]  r_hold_cnt [NCORES];
   logic [8:0]          r_next_job;

   logic [NCORES-1:0]   w_run;
   logic [NCORES-1:0]   w_idle;
   logic [NCORES-1:0]   w_valid;
   logic [NCORES-1:0]   w_valid_oh;
   logic [NCORES-1:0]   w_retire;
   logic [NCORES-1:0]   w_disp_oh;
   logic [c_POP_W-1:0]  w_retire_cnt;
   logic [8:0]          w_jobs_next;
   logic [47:0]         w_key;
   logic                w_abort;

`ifdef CRYPTO1_SCHED_ABORT_EN
   assign w_abort = ABORT;
`else
   assign w_abort = 1'b0;
`endif

   // Slot classification, lowest-index selection for dispatch/key, retire count
   always_comb begin
      w_run        = '0;
      w_idle       = '0;
      w_key        = '0;
      w_retire_cnt = '0;
      for (int i = 0; i < NCORES; i++) begin
         w_run[i]  = (r_slot[i] == SL_RUN);
         w_idle[i] = (r_slot[i] == SL_IDLE);
      end
      // Core handshakes only count while the slot is actually running its job
      w_valid    = w_run & CORE_VALID;
      w_retire   = w_run & CORE_DONE;
      // x & -x isolates the lowest set bit: lowest index has priority
      w_valid_oh = w_valid & (~w_valid + NCORES'(1));
      w_disp_oh  = r_next_job[8] ? '0 : (w_idle & (~w_idle + NCORES'(1)));
      for (int i = 0; i < NCORES; i++) begin
         if (w_valid_oh[i]) begin
            w_key = w_key | CORE_KEY[48*i +: 48];
         end
         w_retire_cnt = w_retire_cnt + c_POP_W'(w_retire[i]);
      end
      w_jobs_next = JOBS_DONE + 9'(w_retire_cnt);
   end

   // Search control, per-slot job lifecycle and all registered outputs
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_state        <= ST_IDLE;
         r_next_job     <= '0;
         BUSY           <= 1'b0;
         DONE           <= 1'b0;
         FOUND          <= 1'b0;
         KEY            <= '0;
         JOBS_DONE      <= '0;
         CORE_BITSTREAM <= '0;
         CORE_RESETn    <= '0;
         CORE_EIDX      <= '0;
         CORE_OIDX      <= '0;
         for (int i = 0; i < NCORES; i++) begin
            r_slot[i]     <= SL_IDLE;
            r_hold_cnt[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               CORE_RESETn <= '0;
               if (START) begin
                  CORE_BITSTREAM <= BITSTREAM;
                  DONE           <= 1'b0;
                  FOUND          <= 1'b0;
                  KEY            <= '0;
                  JOBS_DONE      <= '0;
                  r_next_job     <= '0;
                  BUSY           <= 1'b1;
                  r_state        <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (|w_valid) begin
                  // A recovered key beats any plain retirement in this cycle;
                  // jobs still in flight are abandoned and not counted.
                  FOUND       <= 1'b1;
                  KEY         <= w_key;
                  JOBS_DONE   <= JOBS_DONE + 9'd1;
                  CORE_RESETn <= '0;
                  for (int i = 0; i < NCORES; i++) begin
                     r_slot[i] <= SL_IDLE;
                  end
                  r_state <= ST_FINISH;
               end else if (w_abort) begin
                  CORE_RESETn <= '0;
                  for (int i = 0; i < NCORES; i++) begin
                     r_slot[i] <= SL_IDLE;
                  end
                  r_state <= ST_FINISH;
               end else begin
                  for (int i = 0; i < NCORES; i++) begin
                     case (r_slot[i])
                        SL_IDLE: begin
                           if (w_disp_oh[i]) begin
                              r_slot[i]          <= SL_HOLD;
                              r_hold_cnt[i]      <= c_HOLD_LOAD;
                              CORE_EIDX[4*i +: 4] <= r_next_job[7:4];
                              CORE_OIDX[4*i +: 4] <= r_next_job[3:0];
                              CORE_RESETn[i]     <= 1'b0;
                           end
                        end
                        SL_HOLD: begin
                           if (r_hold_cnt[i] == '0) begin
                              CORE_RESETn[i] <= 1'b1;
                              r_slot[i]      <= SL_RUN;
                           end else begin
                              r_hold_cnt[i] <= r_hold_cnt[i] - c_CNT_W'(1);
                           end
                        end
                        SL_RUN: begin
                           if (w_retire[i]) begin
                              CORE_RESETn[i] <= 1'b0;
                              r_slot[i]      <= SL_IDLE;
                           end
                        end
                        default: begin
                           r_slot[i] <= SL_IDLE;
                        end
                     endcase
                  end
                  if (|w_disp_oh) begin
                     r_next_job <= r_next_job + 9'd1;
                  end
                  JOBS_DONE <= w_jobs_next;
                  // Every job retired means every slot is already idle
                  if (w_jobs_next == c_JOB_TOTAL) begin
                     r_state <= ST_FINISH;
                  end
               end
            end

            ST_FINISH: begin
               CORE_RESETn <= '0;
               BUSY        <= 1'b0;
               DONE        <= 1'b1;
               r_state     <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_crypto1_sched.sv
//==============================================================================
// Module   : tb_crypto1_sched
// Brief    : Self-checking bench for crypto1_sched with behavioural cores and
//            a search-level reference model. Define CRYPTO1_SCHED_ABORT_EN to
//            also exercise the abort input.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_crypto1_sched;

   localparam int NC   = 4;
   localparam int RSTC = 2;

   logic          CLK = 1'b0;
   logic          RESETn = 1'b0;
   logic          START = 1'b0;
   logic [47:0]   BITSTREAM = '0;
`ifdef CRYPTO1_SCHED_ABORT_EN
   logic          ABORT = 1'b0;
`endif
   logic          BUSY, DONE, FOUND;
   logic [47:0]   KEY, CORE_BITSTREAM;
   logic [8:0]    JOBS_DONE;
   logic [NC-1:0] CORE_RESETn;
   logic [4*NC-1:0] CORE_EIDX, CORE_OIDX;
   logic [NC-1:0] core_done = '0;
   logic [NC-1:0] core_valid = '0;
   logic [47:0]   ckey [NC];
   logic [48*NC-1:0] core_key;

   assign core_key = {ckey[3], ckey[2], ckey[1], ckey[0]};

   crypto1_sched #(.NCORES(NC), .RST_CYCLES(RSTC)) dut (
      .CLK(CLK), .RESETn(RESETn), .START(START), .BITSTREAM(BITSTREAM),
`ifdef CRYPTO1_SCHED_ABORT_EN
      .ABORT(ABORT),
`endif
      .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND), .KEY(KEY), .JOBS_DONE(JOBS_DONE),
      .CORE_BITSTREAM(CORE_BITSTREAM), .CORE_RESETn(CORE_RESETn),
      .CORE_EIDX(CORE_EIDX), .CORE_OIDX(CORE_OIDX), .CORE_DONE(core_done),
      .CORE_VALID(core_valid), .CORE_KEY(core_key)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [47:0] rnd48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   // Reference model state (search-level view)
   int          m_phase = 0;      // 0 waiting, 1 searching, 2 wrapping up
   logic        m_busy = 0, m_done = 0, m_found = 0;
   logic [47:0] m_key = '0, m_bs = '0;
   int          m_jobs = 0;
   int          pos_cnt = 0, start_cyc = 0;
   bit          lat_pend = 0;
   int          exp_disp = 0;
   bit          chk_en = 0;

   // Behavioural core controls
   int          fixed_dur = 10;
   bit          stale_en = 0;
   bit          tgt_en = 0;
   logic [7:0]  tgt_job = '0;
   logic [47:0] tgt_key = '0;
   logic [NC-1:0] force_mask = '0;
   logic [47:0] force_key [NC];
   logic [7:0]  cjob [NC];
   int          ccnt [NC];
   int          cdur [NC];
   logic [NC-1:0] prev_rn = '0;
   logic [7:0]  prev_idx [NC];
   int          max_seen = -1;

   // Reference model: advance expected outputs from pre-edge inputs
   always @(posedge CLK) begin
      logic [NC-1:0] r, v;
      int sel;
      pos_cnt++;
      if (!RESETn) begin
         m_phase = 0; m_busy = 0; m_done = 0; m_found = 0;
         m_key = '0; m_bs = '0; m_jobs = 0; lat_pend = 0; exp_disp = 0;
      end else if (m_phase == 0) begin
         if (START) begin
            m_bs = BITSTREAM; m_busy = 1; m_done = 0; m_found = 0;
            m_key = '0; m_jobs = 0; m_phase = 1;
            exp_disp = 0; lat_pend = 1; start_cyc = pos_cnt;
         end
      end else if (m_phase == 1) begin
         r = CORE_RESETn;
         v = r & core_valid;
         if (v != '0) begin
            sel = 0;
            for (int i = NC - 1; i >= 0; i--) if (v[i]) sel = i;
            m_found = 1; m_key = ckey[sel]; m_jobs++; m_phase = 2;
         end
`ifdef CRYPTO1_SCHED_ABORT_EN
         else if (ABORT) m_phase = 2;
`endif
         else begin
            m_jobs += $countones(r & core_done);
            if (m_jobs == 256) m_phase = 2;
         end
      end else begin
         m_busy = 0; m_done = 1; m_phase = 0;
      end
   end

   // Per-cycle compare plus behavioural cores
   always @(negedge CLK) begin
      logic [7:0] idx;
      if (chk_en) begin
         chk("BUSY", 64'(BUSY), 64'(m_busy));
         chk("DONE", 64'(DONE), 64'(m_done));
         chk("FOUND", 64'(FOUND), 64'(m_found));
         chk("KEY", 64'(KEY), 64'(m_key));
         chk("JOBS_DONE", 64'(JOBS_DONE), 64'(m_jobs));
         chk("CORE_BITSTREAM", 64'(CORE_BITSTREAM), 64'(m_bs));
         if (m_phase != 1) chk("cores_held", 64'(CORE_RESETn), 64'(0));
      end
      for (int i = 0; i < NC; i++) begin
         idx = {CORE_EIDX[4*i +: 4], CORE_OIDX[4*i +: 4]};
         if (chk_en && idx != prev_idx[i] && int'(idx) > max_seen) max_seen = int'(idx);
         prev_idx[i] = idx;
         if (!CORE_RESETn[i]) begin
            ccnt[i] = 0;
            if (stale_en) begin
               core_done[i]  = 1'($urandom_range(0, 1));
               core_valid[i] = 1'($urandom_range(0, 1));
               ckey[i]       = rnd48();
            end else begin
               core_done[i] = 1'b0; core_valid[i] = 1'b0; ckey[i] = '0;
            end
         end else begin
            if (!prev_rn[i]) begin
               cjob[i] = idx;
               chk("dispatch_order", 64'(idx), 64'(exp_disp));
               exp_disp++;
               if (lat_pend) begin
                  chk("start_latency", 64'(pos_cnt - start_cyc), 64'(1 + RSTC));
                  lat_pend = 0;
               end
               cdur[i] = (fixed_dur > 0) ? fixed_dur : int'($urandom_range(1, 20));
               core_done[i] = 1'b0; core_valid[i] = 1'b0; ckey[i] = '0;
            end else begin
               chk("index_stable", 64'(idx), 64'(cjob[i]));
            end
            ccnt[i]++;
            if (ccnt[i] == cdur[i]) begin
               core_done[i] = 1'b1;
               if (tgt_en && cjob[i] == tgt_job) begin
                  core_valid[i] = 1'b1; ckey[i] = tgt_key;
               end
            end
            if (force_mask[i]) begin
               core_done[i] = 1'b1; core_valid[i] = 1'b1; ckey[i] = force_key[i];
            end
         end
      end
      prev_rn = CORE_RESETn;
   end

   task automatic do_start(input logic [47:0] bs);
      @(negedge CLK); START = 1'b1; BITSTREAM = bs;
      @(negedge CLK); START = 1'b0;
   endtask

   task automatic wait_done(input int lim, input bit spam);
      int n = 0;
      while (!DONE && n < lim) begin
         @(negedge CLK);
         n++;
         if (spam && !DONE) begin
            START = ($urandom_range(0, 15) == 0);
            BITSTREAM = rnd48();
         end
      end
      START = 1'b0;
      chk("wait_done", 64'(DONE), 64'(1));
   endtask

   task automatic wait_jobs(input int val, input int lim);
      int n = 0;
      while (int'(JOBS_DONE) != val && n < lim) begin
         @(negedge CLK);
         n++;
      end
      chk("wait_jobs", 64'(JOBS_DONE), 64'(val));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      logic [47:0] bs0;
      int n, j;
      for (int i = 0; i < NC; i++) begin
         ckey[i] = '0; force_key[i] = '0; cjob[i] = '0;
         ccnt[i] = 0; cdur[i] = 0; prev_idx[i] = '0;
      end
      repeat (3) @(negedge CLK);
      chk_en = 1;
      chk("rst_BUSY", 64'(BUSY), 64'(0));
      chk("rst_DONE", 64'(DONE), 64'(0));
      chk("rst_JOBS", 64'(JOBS_DONE), 64'(0));
      chk("rst_CORE_RESETn", 64'(CORE_RESETn), 64'(0));
      chk("rst_EIDX", 64'(CORE_EIDX), 64'(0));
      chk("rst_BITSTREAM", 64'(CORE_BITSTREAM), 64'(0));
      RESETn = 1'b1;

      // Exhaustive run, fixed 10-cycle cores, plus START while busy
      fixed_dur = 10; stale_en = 0; tgt_en = 0;
      bs0 = 48'h0123_4567_89AB;
      do_start(bs0);
      repeat (60) @(negedge CLK);
      j = int'(JOBS_DONE);
      do_start(~bs0);
      chk("start_ignored_bs", 64'(CORE_BITSTREAM), 64'(bs0));
      chk("start_ignored_busy", 64'(BUSY), 64'(1));
      wait_done(5000, 0);
      chk("exh_JOBS", 64'(JOBS_DONE), 64'(256));
      chk("exh_FOUND", 64'(FOUND), 64'(0));
      chk("exh_KEY", 64'(KEY), 64'(0));
      chk("exh_BUSY", 64'(BUSY), 64'(0));
      chk("exh_dispatched", 64'(exp_disp), 64'(256));

      // Key found on job 0x5A
      tgt_en = 1; tgt_job = 8'h5A; tgt_key = 48'hA0A1_A2A3_A4A5;
      max_seen = -1;
      do_start(48'h5555_AAAA_0F0F);
      n = 0;
      while (!FOUND && n < 5000) begin @(negedge CLK); n++; end
      chk("found_seen", 64'(FOUND), 64'(1));
      chk("found_cores_reset", 64'(CORE_RESETn), 64'(0));
      wait_done(10, 0);
      chk("found_KEY", 64'(KEY), 64'hA0A1_A2A3_A4A5);
      chk("found_max_job", 64'(max_seen <= 8'h5D), 64'(1));
      tgt_en = 0;

      // Cores 1 and 3 report keys in the same cycle
      fixed_dur = 300;
      do_start(48'h1111_2222_3333);
      n = 0;
      while (CORE_RESETn != '1 && n < 100) begin @(negedge CLK); n++; end
      chk("all_running", 64'(CORE_RESETn), 64'hF);
      force_key[1] = 48'h1111_1111_1111;
      force_key[3] = 48'h3333_3333_3333;
      force_mask = 4'b1010;
      wait_done(20, 0);
      force_mask = '0;
      chk("multi_valid_KEY", 64'(KEY), 64'h1111_1111_1111);
      chk("multi_valid_FOUND", 64'(FOUND), 64'(1));

      // Reset mid-search at JOBS_DONE=100, then restart from job 0
      fixed_dur = 10;
      do_start(48'hDEAD_BEEF_CAFE);
      wait_jobs(100, 3000);
      RESETn = 1'b0;
      @(negedge CLK);
      chk("mid_rst_BUSY", 64'(BUSY), 64'(0));
      chk("mid_rst_JOBS", 64'(JOBS_DONE), 64'(0));
      chk("mid_rst_CORE_RESETn", 64'(CORE_RESETn), 64'(0));
      chk("mid_rst_EIDX", 64'(CORE_EIDX), 64'(0));
      chk("mid_rst_OIDX", 64'(CORE_OIDX), 64'(0));
      chk("mid_rst_BITSTREAM", 64'(CORE_BITSTREAM), 64'(0));
      RESETn = 1'b1;
      do_start(48'hFEED_0000_1234);
      n = 0;
      while (!CORE_RESETn[0] && n < 20) begin @(negedge CLK); n++; end
      chk("restart_job0", 64'({CORE_EIDX[3:0], CORE_OIDX[3:0]}), 64'(0));
      wait_done(5000, 0);
      chk("restart_JOBS", 64'(JOBS_DONE), 64'(256));

`ifdef CRYPTO1_SCHED_ABORT_EN
      // Abort at JOBS_DONE=37
      do_start(48'h0BAD_F00D_0001);
      wait_jobs(37, 3000);
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      wait_done(10, 0);
      chk("abort_JOBS", 64'(JOBS_DONE), 64'(37));
      chk("abort_FOUND", 64'(FOUND), 64'(0));
      chk("abort_cores_held", 64'(CORE_RESETn), 64'(0));
`endif

      // Randomized searches: random durations, stale core outputs, START spam
      for (int it = 0; it < 3; it++) begin
         fixed_dur = 0; stale_en = 1;
         tgt_en = ($urandom_range(0, 3) != 0);
         tgt_job = 8'($urandom_range(0, 255));
         tgt_key = rnd48();
         do_start(rnd48());
         wait_done(20000, 1);
      end
      stale_en = 0; tgt_en = 0;
      repeat (3) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
